// File: rtl/uart_pkg.sv
// Shared UART frame constants and transmitter state encoding.
// The receiver imports the same frame constants so both ends agree on the line format.
package uart_pkg;

  localparam int   DATA_W      = 8;
  localparam logic START_LVL   = 1'b0;
  localparam logic STOP_LVL    = 1'b1;
  localparam bit   PARITY_EVEN = 1'b1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARM      = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_PARITY   = 3'd4;
  localparam logic [2:0] ST_STOP     = 3'd5;
  localparam logic [2:0] ST_ACK_WAIT = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    ARM      = ST_ARM,
    START    = ST_START,
    DATA     = ST_DATA,
    PARITY   = ST_PARITY,
    STOP     = ST_STOP,
    ACK_WAIT = ST_ACK_WAIT
  } tx_state_t;

endpackage

// File: rtl/uart_tx_retry.sv
// UART transmitter: start, DATA_W bits LSB first, optional parity, stop,
// then a NACK listen window that triggers bounded retransmission of the same byte.
module uart_tx_retry #(
  parameter int DATA_W    = uart_pkg::DATA_W,
  parameter int MAX_RETRY = 3,
  parameter int ACK_TICKS = 2
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              tx_tick,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              p_enbl,
  input  logic              fb,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [1:0]        retry_cnt
);

  import uart_pkg::*;

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WIN_W = (ACK_TICKS > 1) ? $clog2(ACK_TICKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [WIN_W-1:0] LAST_WIN  = WIN_W'(ACK_TICKS - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  tx_state_t         state, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic [IDX_W-1:0]  bit_idx, idx_d;
  logic [WIN_W-1:0]  win_cnt, win_d;
  logic              nack_seen, nack_d;
  logic [1:0]        retry_d;
  logic              tx_d, done_d, fail_d;
  logic              par_bit;

  assign din_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign par_bit   = PARITY_EVEN ? ^data_q : ~^data_q;

  // Acceptance ignores tx_tick; every other transition waits for a tick.
  // A NACK arriving on the closing window tick still counts via the direct fb term.
  always_comb begin
    state_d = state;
    data_d  = data_q;
    par_d   = par_q;
    idx_d   = bit_idx;
    win_d   = win_cnt;
    nack_d  = nack_seen;
    retry_d = retry_cnt;
    tx_d    = tx;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    case (state)
      IDLE: begin
        tx_d = STOP_LVL;
        if (din_valid) begin
          data_d  = din;
          par_d   = p_enbl;
          state_d = ARM;
        end
      end
      ARM: begin
        if (tx_tick) begin
          tx_d    = START_LVL;
          state_d = START;
        end
      end
      START: begin
        if (tx_tick) begin
          tx_d    = data_q[0];
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tx_tick) begin
          if (bit_idx == LAST_IDX) begin
            if (par_q) begin
              tx_d    = par_bit;
              state_d = PARITY;
            end else begin
              tx_d    = STOP_LVL;
              state_d = STOP;
            end
          end else begin
            idx_d = bit_idx + 1'b1;
            tx_d  = data_q[idx_d];
          end
        end
      end
      PARITY: begin
        if (tx_tick) begin
          tx_d    = STOP_LVL;
          state_d = STOP;
        end
      end
      STOP: begin
        tx_d = STOP_LVL;
        if (tx_tick) begin
          win_d   = '0;
          nack_d  = 1'b0;
          state_d = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        tx_d = STOP_LVL;
        if (fb) nack_d = 1'b1;
        if (tx_tick) begin
          if (win_cnt == LAST_WIN) begin
            if (!(nack_seen || fb)) begin
              done_d  = 1'b1;
              retry_d = '0;
              state_d = IDLE;
            end else if (retry_cnt < RETRY_MAX) begin
              retry_d = retry_cnt + 1'b1;
              state_d = ARM;
            end else begin
              fail_d  = 1'b1;
              retry_d = '0;
              state_d = IDLE;
            end
          end else begin
            win_d = win_cnt + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = STOP_LVL;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      data_q    <= '0;
      par_q     <= 1'b0;
      bit_idx   <= '0;
      win_cnt   <= '0;
      nack_seen <= 1'b0;
      retry_cnt <= '0;
      tx        <= STOP_LVL;
      done      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      bit_idx   <= idx_d;
      win_cnt   <= win_d;
      nack_seen <= nack_d;
      retry_cnt <= retry_d;
      tx        <= tx_d;
      done      <= done_d;
      fail      <= fail_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_retry.sv
// Scoreboard bench for uart_tx_retry: stimulus pushes expected frames/outcomes,
// a monitor decodes the serial line on every tick and pops/compares.
module tb_uart_tx_retry;
  import uart_pkg::*;

  localparam int MAX_RETRY = 3;
  localparam int ACK_TICKS = 2;
  localparam int TICK_DIV  = 4;

  logic              clk = 1'b0;
  logic              areset, tx_tick, din_valid, din_ready, p_enbl, fb;
  logic              tx, busy, done, fail;
  logic [DATA_W-1:0] din;
  logic [1:0]        retry_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] bits;
    int          nbits;
    int          retry;
  } frame_t;

  typedef struct {
    bit is_fail;
    int ticks;
  } outcome_t;

  frame_t   frame_q[$];
  outcome_t outcome_q[$];

  always #5 clk = ~clk;

  uart_tx_retry #(.DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY), .ACK_TICKS(ACK_TICKS)) dut (
    .clk(clk), .areset(areset), .tx_tick(tx_tick), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .p_enbl(p_enbl), .fb(fb), .tx(tx), .busy(busy),
    .done(done), .fail(fail), .retry_cnt(retry_cnt)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Reference frame: line levels in transmit order, parity from a ones count.
  function automatic frame_t model_frame(input logic [7:0] data, input bit par, input int retry);
    frame_t f;
    int ones = 0;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f.bits[1+i] = data[i];
      ones += int'(data[i]);
    end
    if (par) begin
      f.bits[9]  = logic'(ones % 2);
      f.bits[10] = 1'b1;
      f.nbits    = 11;
    end else begin
      f.bits[9] = 1'b1;
      f.nbits   = 10;
    end
    f.retry = retry;
    return f;
  endfunction

  task automatic step(input logic tick, input logic fbv, input logic valid, input logic [7:0] d);
    @(negedge clk);
    tx_tick   = tick;
    fb        = fbv;
    din_valid = valid;
    din       = d;
  endtask

  task automatic accept(input logic [7:0] data, input bit par, input bit on_tick);
    @(negedge clk);
    check("ready_in_idle", din_ready, 1'b1);
    tx_tick   = on_tick;
    fb        = 1'b0;
    din_valid = 1'b1;
    din       = data;
    p_enbl    = par;
    @(posedge clk);
    #1;
    check("ready_low_after_accept", din_ready, 1'b0);
    check("busy_after_accept", busy, 1'b1);
    if (on_tick) check("tick_unused_on_accept", tx, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    p_enbl = 1'($urandom);
  endtask

  // mode 0: fb pulse mid-window, 1: fb on the closing window tick, 2: fb held high.
  task automatic send_byte(input logic [7:0] data, input bit par, input int n_nack,
                           input int mode, input bit on_tick, input bit noise);
    int nb      = par ? 11 : 10;
    int nframes = (n_nack > MAX_RETRY) ? MAX_RETRY + 1 : n_nack + 1;
    int last_t  = nb + 1 + ACK_TICKS;
    outcome_t o;
    for (int f = 0; f < nframes; f++) frame_q.push_back(model_frame(data, par, f));
    o.is_fail = (n_nack > MAX_RETRY);
    o.ticks   = nb + ACK_TICKS;
    outcome_q.push_back(o);
    accept(data, par, on_tick);
    for (int f = 0; f < nframes; f++) begin
      bit nack = (f < n_nack);
      for (int t = 1; t <= last_t; t++) begin
        for (int c = 0; c < TICK_DIV; c++) begin
          logic tick  = (c == TICK_DIV - 1);
          logic fbv   = 1'b0;
          logic valid = noise && (t < last_t);
          if (mode == 2) fbv = 1'b1;
          else if (nack && mode == 0 && t == nb + 2 && c == 1) fbv = 1'b1;
          else if (nack && mode == 1 && t == last_t && tick) fbv = 1'b1;
          else if (!nack && noise && t == 4 && c == 0) fbv = 1'b1;
          step(tick, fbv, valid, 8'($urandom));
        end
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    repeat ($urandom_range(1, 5)) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic reset_mid_frame();
    frame_q.push_back(model_frame(8'hFF, 1'b0, 0));
    accept(8'hFF, 1'b0, 1'b0);
    for (int t = 0; t < 5 * TICK_DIV; t++) step(t % TICK_DIV == TICK_DIV - 1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #2 areset = 1'b1;
    #1;
    check("reset_tx_high", tx, 1'b1);
    check("reset_busy_low", busy, 1'b0);
    check("reset_done_low", done, 1'b0);
    check("reset_fail_low", fail, 1'b0);
    check("reset_retry_zero", retry_cnt, 2'd0);
    frame_q.delete();
    outcome_q.delete();
    repeat (2) @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", din_ready, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: decode the line on each tick, compare frames and outcomes from the queues.
  initial begin
    bit          in_frame = 0;
    bit          tracking = 0;
    int          idx      = 0;
    int          since    = 0;
    logic [10:0] got      = '1;
    frame_t      cur;
    outcome_t    o;
    forever begin
      @(posedge clk);
      #1;
      if (areset) begin
        in_frame = 0;
        tracking = 0;
        continue;
      end
      if (done && fail) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_fail_exclusive: got done=%0b fail=%0b, want not both", done, fail);
      end
      if (tx_tick) begin
        if (tracking) since++;
        if (in_frame) begin
          got[idx] = tx;
          idx++;
          if (idx == cur.nbits) begin
            check("frame_bits", got, cur.bits);
            in_frame = 0;
          end
        end else if (tx == 1'b0) begin
          if (frame_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_frame: got start bit, want none");
          end else begin
            cur      = frame_q.pop_front();
            got      = '1;
            got[0]   = tx;
            idx      = 1;
            in_frame = 1;
            since    = 0;
            tracking = 1;
            check("retry_cnt_at_start", retry_cnt, cur.retry);
          end
        end
      end
      if (done || fail) begin
        if (outcome_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_outcome: got done=%0b fail=%0b, want none", done, fail);
        end else begin
          o = outcome_q.pop_front();
          check("outcome_is_fail", fail, o.is_fail);
          check("outcome_tick", since, o.ticks);
          check("retry_cleared", retry_cnt, 2'd0);
          check("idle_after_outcome", busy, 1'b0);
        end
        tracking = 0;
      end
    end
  end

  initial begin
    areset    = 1'b1;
    tx_tick   = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    p_enbl    = 1'b0;
    fb        = 1'b0;
    #12;
    check("init_tx_high", tx, 1'b1);
    check("init_busy_low", busy, 1'b0);
    check("init_done_low", done, 1'b0);
    check("init_fail_low", fail, 1'b0);
    check("init_retry_zero", retry_cnt, 2'd0);
    @(negedge clk);
    areset = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);

    send_byte(8'hA5, 1'b0, 0, 0, 1'b0, 1'b0);
    send_byte(8'h07, 1'b1, 0, 0, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b1, 1, 0, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 4, 2, 1'b0, 1'b0);
    send_byte(8'($urandom), 1'b1, 0, 0, 1'b1, 1'b0);
    send_byte(8'h96, 1'b0, 2, 1, 1'b0, 1'b1);
    reset_mid_frame();
    send_byte(8'h81, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      int r      = $urandom_range(0, 5);
      int n_nack = (r <= 1) ? 0 : r - 1;
      send_byte(8'($urandom), 1'($urandom), n_nack, $urandom_range(0, 1),
                1'($urandom), 1'($urandom));
    end

    repeat (5) step(1'b0, 1'b0, 1'b0, 8'h00);
    check("frames_left", frame_q.size(), 0);
    check("outcomes_left", outcome_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
